req_queue: RTL and testbench
============================

Name: req_queue

Overview:
- Request queue directly upstream of the SPI serializer.
- Buffers {opcode, addr} requests from the core and offers them one at a time on the serializer's valid_in / ready_out interface.
- The serializer's ready_out is a level, not a per-transfer acknowledge. This block therefore infers capture from ready_out falling, and completion from ready_out rising.
- Monitors the serializer's err flag so an aborted transfer is reported as dropped, or retried when the optional feature is compiled in.

Parameters:
- ADDRW, 8, address width; must match serializer.
- OPCODEW, 2, opcode width; must match serializer.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_RETRY, 3, re-offers per entry after err; used only with REQ_QUEUE_RETRY_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- push_valid  in  1  core request strobe.
- push_opcode  in  OPCODEW  request opcode.
- push_addr  in  ADDRW  request address.
- push_ready  out  1  FIFO not full.
- ser_valid  out  1  to serializer valid_in.
- ser_opcode  out  OPCODEW  to serializer opcode.
- ser_addr  out  ADDRW  to serializer addr.
- ser_ready  in  1  from serializer ready_out.
- ser_err  in  1  from serializer err.
- count  out  clog2(DEPTH+1)  FIFO occupancy; excludes the held entry.
- overflow  out  1  one-cycle pulse: push rejected.
- drop  out  1  one-cycle pulse: held entry discarded after err.

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst_n is synchronous, active-low.
  - Reset values: push_ready=1, ser_valid=0, ser_opcode=0, ser_addr=0, count=0, overflow=0, drop=0, state=IDLE, pointers=0, ser_ready_q=1, retry_cnt=0.
  - Reset mid-transfer discards all entries, including the held one; no drop pulse.
- Push side:
  - Entry written when push_valid && push_ready.
  - push_ready = (count != DEPTH), registered.
  - Push while full: entry discarded, overflow=1 on the next cycle.
  - A pop on the same cycle does not make a full FIFO accept a push.
  - Push and pop on the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Pop side: registered ser_ready_q tracks edges. FSM:
  - IDLE -> OFFER when count != 0 && ser_ready==1.
    - Head copied into holding register, which drives ser_opcode/ser_addr.
    - Head popped (count-1); retry_cnt cleared.
  - OFFER: ser_valid=1; holding register stable.
    - ser_ready_q==1 && ser_ready==0 (capture) -> BUSY, ser_valid=0 next cycle.
    - ser_err ignored in OFFER.
  - BUSY: ser_valid=0.
    - If ser_err==1 -> error handling (see Optional Feature). ser_err has priority over a simultaneous ser_ready rise.
    - Else if ser_ready==1 -> IDLE (transfer complete).
- Latency:
  - Push into empty FIFO with idle serializer: ser_valid high 2 clk after the push cycle.
  - BUSY->IDLE->OFFER costs 2 clk per back-to-back entry.
- ser_valid is never high while state==BUSY. This prevents the serializer reloading a completed entry.

Optional Feature:
- Macro: REQ_QUEUE_RETRY_EN.
- Defined:
  - On ser_err in BUSY with retry_cnt < MAX_RETRY: retry_cnt+1 and -> OFFER; the held entry is re-offered unchanged, and FIFO contents are untouched.
  - When retry_cnt == MAX_RETRY: drop=1, -> IDLE.
- Undefined:
  - On ser_err in BUSY: drop=1, held entry discarded, -> IDLE.
  - retry_cnt logic and MAX_RETRY are absent.

Decomposition:
- Shared package (reused by the serializer):
  - ADDRW/OPCODEW defaults.
  - Entry width OPCODEW+ADDRW.
  - clog2 function.
  - FSM state encoding IDLE/OFFER/BUSY.
- One sub-module, req_fifo: storage array, rd/wr pointers, count, full/empty, overflow.
- req_queue holds the FSM, holding register and err handling.

Test Plan:
- Reset then push {2'b10, 8'hA5} with ser_ready=1 -> ser_valid=1 after 2 clk, ser_opcode=2'b10, ser_addr=8'hA5, count=0.
- Serializer model drops ready for 10 clk, then raises it -> ser_valid falls 1 clk after ready falls; state IDLE after rise; next entry offered 2 clk later.
- Push 5 entries into DEPTH=4 with ser_ready held 0 -> push_ready=0 after 4th; 5th gives overflow pulse; count=4; entries later emerge in order, 5th never appears.
- Push and pop on the same cycle at count=2 -> count stays 2; pointer wrap verified over 9 entries in order.
- ser_err pulse in BUSY, macro undefined -> drop=1 for 1 clk, entry lost, next entry offered.
- Macro defined, MAX_RETRY=3:
  - err 4 times on the same entry -> 3 re-offers of identical opcode/addr, then drop=1.
  - rst_n=0 for 1 clk mid-BUSY -> all outputs at reset values, count=0.

Source files
------------

// File: rtl/req_queue_pkg.sv
// rtl/req_queue_pkg.sv - shared widths, state encoding and helpers for the SPI request path
// Purpose: common definitions used by req_queue, req_fifo and the downstream serializer.
// Ports: none (package).
package req_queue_pkg;

  // Default field widths; the serializer must be built with the same values.
  localparam int ADDRW_DEF   = 8;
  localparam int OPCODEW_DEF = 2;
  localparam int ENTRY_W_DEF = OPCODEW_DEF + ADDRW_DEF;

  // Width of one stored request {opcode, addr}.
  function automatic int entry_w(input int opcodew, input int addrw);
    return opcodew + addrw;
  endfunction

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Request hand-off state, shared with the serializer for debug visibility.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } req_state_t;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - request storage FIFO with registered push_ready and overflow pulse
// Purpose: DEPTH-entry circular buffer feeding the req_queue hand-off FSM.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push_valid/push_data write request; accepted only when not full
//   pop                 remove head (ignored when empty)
//   head_data           current head entry (valid when !empty)
//   count               occupancy
//   full, empty         status flags; full is registered
//   overflow            one-cycle pulse, cycle after a push hit a full FIFO
module req_fifo
  import req_queue_pkg::*;
#(
  parameter int WIDTH = ENTRY_W_DEF,
  parameter int DEPTH = 4,
  localparam int PTRW = clog2(DEPTH),
  localparam int CNTW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_ready_q, push_ready_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;
  logic             rd_en;

  // Acceptance uses the registered ready, so a pop in the same cycle never
  // lets a full FIFO take a push.
  assign wr_en = push_valid && push_ready_q;
  assign rd_en = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Ready follows the next occupancy so it is exact on every cycle.
    push_ready_d = (count_d != CNTW'(DEPTH));
    overflow_d   = push_valid && !push_ready_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      push_ready_q <= push_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset; stale contents are never observable past the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = !push_ready_q;
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;

endmodule

// File: rtl/req_queue.sv
// rtl/req_queue.sv - request queue and level-ready hand-off to the SPI serializer
// Purpose: buffers {opcode, addr} requests and offers them one at a time to the
//   serializer, inferring capture from ser_ready falling and completion from it rising.
// Optional feature macro: REQ_QUEUE_RETRY_EN (re-offer the held entry after ser_err,
//   up to MAX_RETRY times, before dropping it).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   push_valid/push_opcode/push_addr   core request
//   push_ready                         FIFO not full
//   ser_valid/ser_opcode/ser_addr      request offered to the serializer
//   ser_ready, ser_err                 serializer ready level and error flag
//   count                              FIFO occupancy, excluding the held entry
//   overflow                           pulse: push rejected
//   drop                               pulse: held entry discarded after error
module req_queue
  import req_queue_pkg::*;
#(
  parameter int ADDRW   = ADDRW_DEF,
  parameter int OPCODEW = OPCODEW_DEF,
  parameter int DEPTH   = 4,
`ifdef REQ_QUEUE_RETRY_EN
  parameter int MAX_RETRY = 3,
`endif
  localparam int EW   = entry_w(OPCODEW, ADDRW),
  localparam int CNTW = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  input  logic [OPCODEW-1:0] push_opcode,
  input  logic [ADDRW-1:0]   push_addr,
  output logic               push_ready,
  output logic               ser_valid,
  output logic [OPCODEW-1:0] ser_opcode,
  output logic [ADDRW-1:0]   ser_addr,
  input  logic               ser_ready,
  input  logic               ser_err,
  output logic [CNTW-1:0]    count,
  output logic               overflow,
  output logic               drop
);

`ifdef REQ_QUEUE_RETRY_EN
  localparam int RW = clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
`endif

  req_state_t         state_q, state_d;
  logic [OPCODEW-1:0] hold_opcode_q, hold_opcode_d;
  logic [ADDRW-1:0]   hold_addr_q, hold_addr_d;
  logic               ser_ready_q, ser_ready_d;
  logic               drop_q, drop_d;

  logic               pop;
  logic [EW-1:0]      head_data;
  logic               fifo_full;
  logic               fifo_empty;

  req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  ({push_opcode, push_addr}),
    .pop        (pop),
    .head_data  (head_data),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .overflow   (overflow)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_opcode_q <= '0;
      hold_addr_q   <= '0;
      ser_ready_q   <= 1'b1;
      drop_q        <= 1'b0;
`ifdef REQ_QUEUE_RETRY_EN
      retry_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hold_opcode_q <= hold_opcode_d;
      hold_addr_q   <= hold_addr_d;
      ser_ready_q   <= ser_ready_d;
      drop_q        <= drop_d;
`ifdef REQ_QUEUE_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
`endif
    end
  end

  // Next-state and holding-register logic.
  always_comb begin
    state_d       = state_q;
    hold_opcode_d = hold_opcode_q;
    hold_addr_d   = hold_addr_q;
    ser_ready_d   = ser_ready;
    drop_d        = 1'b0;
    pop           = 1'b0;
`ifdef REQ_QUEUE_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Only start a new offer once the serializer shows it is free.
        if (!fifo_empty && ser_ready) begin
          state_d       = ST_OFFER;
          hold_opcode_d = head_data[EW-1 -: OPCODEW];
          hold_addr_d   = head_data[ADDRW-1:0];
          pop           = 1'b1;
`ifdef REQ_QUEUE_RETRY_EN
          retry_cnt_d   = '0;
`endif
        end
      end
      ST_OFFER: begin
        // A falling ready level is the only sign the serializer took the entry.
        if (ser_ready_q && !ser_ready) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Error wins over a simultaneous completion.
        if (ser_err) begin
`ifdef REQ_QUEUE_RETRY_EN
          if (retry_cnt_q < RW'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = ST_OFFER;
          end else begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end
`else
          drop_d  = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (ser_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. ser_valid is decoded from OFFER alone so it can never be high in
  // BUSY, which keeps the serializer from reloading a finished entry.
  always_comb begin
    ser_valid  = (state_q == ST_OFFER);
    ser_opcode = hold_opcode_q;
    ser_addr   = hold_addr_q;
    push_ready = !fifo_full;
    drop       = drop_q;
  end

endmodule

// File: tb/tb_req_queue.sv
// tb/tb_req_queue.sv - directed self-checking bench for req_queue
// Purpose: drives the core push side and a scripted serializer, checks outputs.
// Ports: none (top-level bench).
module tb_req_queue;

  logic       clk;
  logic       rst_n;
  logic       push_valid;
  logic [1:0] push_opcode;
  logic [7:0] push_addr;
  logic       push_ready;
  logic       ser_valid;
  logic [1:0] ser_opcode;
  logic [7:0] ser_addr;
  logic       ser_ready;
  logic       ser_err;
  logic [2:0] count;
  logic       overflow;
  logic       drop;

  int total = 0;
  int bad   = 0;

  logic [1:0] ent_opc  [9];
  logic [7:0] ent_addr [9];

  req_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_opcode (push_opcode),
    .push_addr   (push_addr),
    .push_ready  (push_ready),
    .ser_valid   (ser_valid),
    .ser_opcode  (ser_opcode),
    .ser_addr    (ser_addr),
    .ser_ready   (ser_ready),
    .ser_err     (ser_err),
    .count       (count),
    .overflow    (overflow),
    .drop        (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] o, input logic [7:0] a);
    push_valid  = 1'b1;
    push_opcode = o;
    push_addr   = a;
    tick();
    push_valid  = 1'b0;
  endtask

  // Wait (bounded) for an offer, check it, then capture and complete it.
  task automatic serve(input logic [1:0] eo, input logic [7:0] ea);
    int n = 0;
    while (ser_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("serve_valid", 32'(ser_valid), 32'd1);
    chk("serve_opcode", 32'(ser_opcode), 32'(eo));
    chk("serve_addr", 32'(ser_addr), 32'(ea));
    ser_ready = 1'b0;
    tick();
    chk("serve_busy_valid", 32'(ser_valid), 32'd0);
    ser_ready = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_push_ready"}, 32'(push_ready), 32'd1);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_ser_opcode"}, 32'(ser_opcode), 32'd0);
    chk({tag, "_ser_addr"}, 32'(ser_addr), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_drop"}, 32'(drop), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    push_valid  = 1'b0;
    push_opcode = 2'd0;
    push_addr   = 8'd0;
    ser_ready   = 1'b1;
    ser_err     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ent_opc[i]  = 2'(i);
      ent_addr[i] = 8'h40 + 8'(i);
    end

    // Reset state.
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Push into empty FIFO, idle serializer: offer 2 clk after the push.
    push_valid  = 1'b1;
    push_opcode = 2'b10;
    push_addr   = 8'hA5;
    tick();
    push_valid  = 1'b0;
    chk("lat_valid_1clk", 32'(ser_valid), 32'd0);
    chk("lat_count_1clk", 32'(count), 32'd1);
    tick();
    chk("lat_valid_2clk", 32'(ser_valid), 32'd1);
    chk("lat_opcode", 32'(ser_opcode), 32'h2);
    chk("lat_addr", 32'(ser_addr), 32'hA5);
    chk("lat_count", 32'(count), 32'd0);

    // Ready falls (capture) while a second entry is pushed; hold low 10 clk.
    ser_ready = 1'b0;
    push(2'b01, 8'h3C);
    chk("cap_valid_low", 32'(ser_valid), 32'd0);
    chk("cap_count", 32'(count), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("busy_valid_low", 32'(ser_valid), 32'd0);
    chk("busy_hold_addr", 32'(ser_addr), 32'hA5);
    ser_ready = 1'b1;
    tick();
    chk("done_idle_valid", 32'(ser_valid), 32'd0);
    tick();
    chk("next_valid", 32'(ser_valid), 32'd1);
    chk("next_opcode", 32'(ser_opcode), 32'h1);
    chk("next_addr", 32'(ser_addr), 32'h3C);
    chk("next_count", 32'(count), 32'd0);
    ser_ready = 1'b0;
    tick();
    ser_ready = 1'b1;
    tick();

    // Overflow: 5 pushes into DEPTH=4 with the serializer not ready.
    ser_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      push(2'(3 - i), 8'h10 + 8'(i));
      if (i == 3) begin
        chk("full_push_ready", 32'(push_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_no_overflow", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    tick();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) serve(2'(3 - i), 8'h10 + 8'(i));
    tick();
    tick();
    chk("ovf_fifth_absent", 32'(ser_valid), 32'd0);
    chk("ovf_drained_count", 32'(count), 32'd0);
    chk("ovf_ready_back", 32'(push_ready), 32'd1);

    // Simultaneous push and pop at count=2, then 9 entries across pointer wrap.
    ser_ready = 1'b0;
    push(ent_opc[0], ent_addr[0]);
    push(ent_opc[1], ent_addr[1]);
    chk("pp_pre_count", 32'(count), 32'd2);
    ser_ready = 1'b1;
    push(ent_opc[2], ent_addr[2]);
    chk("pp_count_same", 32'(count), 32'd2);
    serve(ent_opc[0], ent_addr[0]);
    for (int k = 3; k < 9; k++) begin
      push(ent_opc[k], ent_addr[k]);
      serve(ent_opc[k - 2], ent_addr[k - 2]);
    end
    serve(ent_opc[7], ent_addr[7]);
    serve(ent_opc[8], ent_addr[8]);
    chk("wrap_count_end", 32'(count), 32'd0);

`ifdef REQ_QUEUE_RETRY_EN
    // Four errors on one entry: three identical re-offers, then a drop.
    push(2'b10, 8'h77);
    tick();
    chk("rt_first_offer", 32'(ser_valid), 32'd1);
    for (int r = 0; r < 4; r++) begin
      ser_ready = 1'b0;
      tick();
      chk("rt_busy_valid", 32'(ser_valid), 32'd0);
      ser_err = 1'b1;
      tick();
      ser_err = 1'b0;
      if (r < 3) begin
        chk("rt_reoffer_valid", 32'(ser_valid), 32'd1);
        chk("rt_reoffer_opcode", 32'(ser_opcode), 32'h2);
        chk("rt_reoffer_addr", 32'(ser_addr), 32'h77);
        chk("rt_reoffer_nodrop", 32'(drop), 32'd0);
        ser_ready = 1'b1;
        tick();
      end else begin
        chk("rt_final_drop", 32'(drop), 32'd1);
        chk("rt_final_valid", 32'(ser_valid), 32'd0);
      end
    end
    ser_ready = 1'b1;
    tick();
    chk("rt_drop_end", 32'(drop), 32'd0);
    chk("rt_count", 32'(count), 32'd0);
    chk("rt_idle_valid", 32'(ser_valid), 32'd0);
`else
    // Error in BUSY: held entry dropped, next entry offered.
    push(2'b11, 8'hE0);
    push(2'b00, 8'hE1);
    chk("err_offer_addr", 32'(ser_addr), 32'hE0);
    ser_ready = 1'b0;
    tick();
    ser_err = 1'b1;
    tick();
    ser_err = 1'b0;
    chk("err_drop", 32'(drop), 32'd1);
    chk("err_valid", 32'(ser_valid), 32'd0);
    chk("err_count", 32'(count), 32'd1);
    ser_ready = 1'b1;
    tick();
    chk("err_drop_end", 32'(drop), 32'd0);
    chk("err_next_addr", 32'(ser_addr), 32'hE1);
    serve(2'b00, 8'hE1);
`endif

    // Reset while BUSY with a queued entry: everything returns to reset values.
    ser_ready = 1'b1;
    push(2'b01, 8'hC0);
    push(2'b10, 8'hC1);
    ser_ready = 1'b0;
    tick();
    chk("mid_busy_valid", 32'(ser_valid), 32'd0);
    chk("mid_busy_count", 32'(count), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst_n     = 1'b1;
    ser_ready = 1'b1;
    tick();
    chk("post_rst_drop", 32'(drop), 32'd0);
    chk("post_rst_valid", 32'(ser_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
